// File: rtl/fp_alu_pkg.sv
// Shared opcode, flag and FSM definitions for the FP ALU sequencer.
package fp_alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_ABS = 4'd4;
  localparam logic [3:0] OP_NEG = 4'd5;
  localparam logic [3:0] OP_MIN = 4'd6;
  localparam logic [3:0] OP_MAX = 4'd7;

  localparam int FLAG_OVF = 0;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INV = 2;
  localparam int FLAG_TMO = 3;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_PUSH} state_t;

  function automatic logic [1:0] op_to_unit(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB: return 2'd0;
      OP_MUL:         return 2'd1;
      OP_DIV:         return 2'd2;
      default:        return 2'd3;
    endcase
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB set.
  function automatic logic [63:0] qnan(input int data_w, input int exp_w);
    logic [63:0] q;
    q = '0;
    for (int i = 0; i < 64; i++)
      if (i >= data_w - exp_w - 2 && i <= data_w - 2) q[i] = 1'b1;
    return q;
  endfunction

endpackage

// File: rtl/fp_alu_sequencer_fifo.sv
// First-word-fall-through result FIFO; head reads as zero while empty.
module fp_result_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fp_alu_sequencer.sv
// Dispatches tagged FP requests to execution units one at a time and queues results.
// Optional WAIT watchdog enabled by FP_ALU_SEQ_TIMEOUT_EN.
module fp_alu_sequencer
  import fp_alu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int EXP_W       = 8,
  parameter int TAG_W       = 4,
  parameter int NUM_UNITS   = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [3:0]                    in_op,
  input  logic [DATA_W-1:0]             in_a,
  input  logic [DATA_W-1:0]             in_b,
  input  logic [TAG_W-1:0]              in_tag,
  output logic [NUM_UNITS-1:0]          unit_start,
  output logic [3:0]                    unit_op,
  output logic [DATA_W-1:0]             unit_a,
  output logic [DATA_W-1:0]             unit_b,
  input  logic [NUM_UNITS-1:0]          unit_done,
  input  logic [NUM_UNITS*DATA_W-1:0]   unit_result,
  input  logic [NUM_UNITS-1:0]          unit_ovf,
  input  logic [NUM_UNITS-1:0]          unit_unf,
  input  logic [NUM_UNITS-1:0]          unit_inv,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_result,
  output logic [TAG_W-1:0]              out_tag,
  output logic [3:0]                    out_flags,
  output logic [3:0]                    sticky_flags,
  input  logic                          sticky_clr,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int SEL_W = $clog2(NUM_UNITS);
  localparam int ENT_W = DATA_W + TAG_W + 4;

  state_t              state, state_next;
  logic [3:0]          op_q;
  logic [DATA_W-1:0]   a_q, b_q, res_q;
  logic [TAG_W-1:0]    tag_q;
  logic [SEL_W-1:0]    sel_q;
  logic [3:0]          flags_q;
  logic                accept, done_sel, timed_out;
  logic                fifo_push, fifo_full, fifo_empty;
  logic [ENT_W-1:0]    fifo_head;

  assign in_ready = !reset && (state == ST_IDLE) && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign done_sel = unit_done[sel_q];
  assign busy     = (state != ST_IDLE);
  assign unit_op  = op_q;
  assign unit_a   = a_q;
  assign unit_b   = b_q;

`ifdef FP_ALU_SEQ_TIMEOUT_EN
  localparam int          TMO_W  = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [63:0] QNAN_V = qnan(DATA_W, EXP_W);
  logic [TMO_W-1:0] wait_cnt;

  // Restarts from zero for every op; counts only while waiting on a unit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  wait_cnt <= '0;
    else if (state == ST_ISSUE) wait_cnt <= '0;
    else if (state == ST_WAIT)  wait_cnt <= wait_cnt + 1'b1;
  end

  assign timed_out = (state == ST_WAIT) && !done_sel && (wait_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unit_start = '0;
    fifo_push  = 1'b0;
    case (state)
      ST_IDLE:  if (accept) state_next = in_op[3] ? ST_PUSH : ST_ISSUE;
      ST_ISSUE: begin
        unit_start[sel_q] = 1'b1;
        state_next        = ST_WAIT;
      end
      ST_WAIT:  if (done_sel || timed_out) state_next = ST_PUSH;
      ST_PUSH:  begin
        fifo_push  = 1'b1;
        state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      sel_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else if (state == ST_IDLE && accept) begin
      op_q             <= in_op;
      a_q              <= in_a;
      b_q              <= in_b;
      tag_q            <= in_tag;
      sel_q            <= SEL_W'(op_to_unit(in_op));
      res_q            <= '0;
      flags_q          <= '0;
      flags_q[FLAG_INV] <= in_op[3];
    end else if (state == ST_WAIT && done_sel) begin
      res_q   <= unit_result[sel_q*DATA_W +: DATA_W];
      flags_q <= {1'b0, unit_inv[sel_q], unit_unf[sel_q], unit_ovf[sel_q]};
`ifdef FP_ALU_SEQ_TIMEOUT_EN
    end else if (timed_out) begin
      res_q             <= QNAN_V[DATA_W-1:0];
      flags_q           <= '0;
      flags_q[FLAG_TMO] <= 1'b1;
      flags_q[FLAG_INV] <= 1'b1;
`endif
    end
  end

  // A push in the same cycle as a clear keeps the new flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           sticky_flags <= '0;
    else if (fifo_push)  sticky_flags <= sticky_clr ? flags_q : (sticky_flags | flags_q);
    else if (sticky_clr) sticky_flags <= '0;
  end

  fp_result_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({res_q, tag_q, flags_q}),
    .pop       (out_valid && out_ready),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid                      = !fifo_empty;
  assign {out_result, out_tag, out_flags} = fifo_head;

endmodule

// File: tb/tb_fp_alu_sequencer.sv
// Directed bench for fp_alu_sequencer with behavioural unit models and a result scoreboard.
module tb_fp_alu_sequencer;
  import fp_alu_pkg::*;

  localparam int DW = 32;
  localparam int TW = 4;
  localparam int NU = 4;
  localparam int FD = 4;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_ready;
  logic [3:0] in_op;
  logic [DW-1:0] in_a, in_b;
  logic [TW-1:0] in_tag;
  logic [NU-1:0] unit_start, unit_done;
  logic [3:0] unit_op;
  logic [DW-1:0] unit_a, unit_b;
  logic [NU*DW-1:0] unit_result;
  logic [NU-1:0] unit_ovf, unit_unf, unit_inv;
  logic out_valid, out_ready;
  logic [DW-1:0] out_result;
  logic [TW-1:0] out_tag;
  logic [3:0] out_flags, sticky_flags;
  logic sticky_clr, busy;
  logic [$clog2(FD):0] fifo_count;

  always #5 clk = ~clk;

  fp_alu_sequencer #(
    .DATA_W(DW), .EXP_W(8), .TAG_W(TW), .NUM_UNITS(NU), .FIFO_DEPTH(FD), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .unit_start(unit_start), .unit_op(unit_op), .unit_a(unit_a), .unit_b(unit_b),
    .unit_done(unit_done), .unit_result(unit_result),
    .unit_ovf(unit_ovf), .unit_unf(unit_unf), .unit_inv(unit_inv),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
    .out_flags(out_flags), .sticky_flags(sticky_flags), .sticky_clr(sticky_clr),
    .busy(busy), .fifo_count(fifo_count)
  );

  // Unit models: done fires mdelay cycles after the start pulse (0 = never).
  logic [DW-1:0] mres [NU];
  int            mdelay [NU];
  int            mcnt [NU];
  logic [NU-1:0] mdone = '0;
  logic [NU-1:0] fdone, movf, munf, minv;

  assign unit_done = mdone | fdone;
  assign unit_ovf  = movf;
  assign unit_unf  = munf;
  assign unit_inv  = minv;

  always_comb begin
    unit_result = '0;
    for (int i = 0; i < NU; i++) unit_result[i*DW +: DW] = mres[i];
  end

  always @(negedge clk) begin
    for (int i = 0; i < NU; i++) begin
      mdone[i] <= 1'b0;
      if (unit_start[i]) mcnt[i] <= mdelay[i];
      else if (mcnt[i] > 0) begin
        mcnt[i] <= mcnt[i] - 1;
        if (mcnt[i] == 1) mdone[i] <= 1'b1;
      end
    end
  end

  int start_cnt = 0;
  logic [DW+TW+3:0] got_q[$];

  always @(negedge clk) begin
    if (unit_start != '0) start_cnt <= start_cnt + 1;
    if (!reset && out_valid && out_ready) got_q.push_back({out_result, out_tag, out_flags});
  end

  int checks = 0;
  int failures = 0;
  logic [DW+TW+3:0] exp_q[$];
  int pushed_total = 0;
  int got_rd = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [TW-1:0] tag, input logic exp_en,
                      input logic [DW-1:0] er, input logic [3:0] ef);
    int c;
    c = 0;
    while (!in_ready && c < 200) begin
      step(1);
      c++;
    end
    if (!in_ready) check("send_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    if (exp_en) begin
      exp_q.push_back({er, tag, ef});
      pushed_total++;
    end
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    while (busy && c < 200) begin
      step(1);
      c++;
    end
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic pulse_done(input int u);
    @(negedge clk);
    fdone[u] = 1'b1;
    @(negedge clk);
    fdone[u] = 1'b0;
  endtask

  task automatic sb_drain(input string tag);
    logic [DW+TW+3:0] e;
    step(2);
    check({tag, "_out_count"}, got_q.size(), pushed_total);
    while (got_rd < got_q.size() && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_sb_entry"}, got_q[got_rd], e);
      got_rd++;
    end
  endtask

  initial begin
    int c;
    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b0; sticky_clr = 1'b0; fdone = '0; movf = '0; munf = '0; minv = '0;
    for (int i = 0; i < NU; i++) begin
      mres[i] = '0;
      mdelay[i] = 1;
      mcnt[i] = 0;
    end
    step(2);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_unit_start", unit_start, 0);
    check("rst_busy", busy, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_sticky", sticky_flags, 0);
    check("rst_out_result", out_result, 0);
    check("rst_unit_a", unit_a, 0);
    reset = 1'b0;
    step(1);
    check("post_rst_in_ready", in_ready, 1);

    // ADD with a stray done from the special unit while waiting on the adder
    mdelay[0] = 3; mres[0] = 32'h4040_0000;
    mdelay[3] = 0; mres[3] = 32'hDEAD_BEEF;
    send(OP_ADD, 32'h3F80_0000, 32'h4000_0000, 4'd5, 1'b1, 32'h4040_0000, 4'b0000);
    check("add_start", unit_start, 4'b0001);
    check("add_unit_a", unit_a, 32'h3F80_0000);
    check("add_unit_b", unit_b, 32'h4000_0000);
    check("add_busy", busy, 1);
    check("add_in_ready", in_ready, 0);
    step(1);
    pulse_done(3);
    c = 0;
    while (!unit_done[0] && c < 50) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("add_done_seen", unit_done[0], 1);
    step(1);
    check("add_valid_at_capture", out_valid, 0);
    check("add_busy_push", busy, 1);
    step(1);
    check("add_out_valid", out_valid, 1);
    check("add_out_result", out_result, 32'h4040_0000);
    check("add_out_tag", out_tag, 5);
    check("add_out_flags", out_flags, 0);
    check("add_fifo_count", fifo_count, 1);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check("add_pop_count", fifo_count, 0);
    sb_drain("add");

    // DIV by zero: invalid flag, sticky capture and clear
    out_ready = 1'b1;
    mdelay[2] = 2; mres[2] = 32'h7F80_0000; minv = 4'b0100;
    send(OP_DIV, 32'h3F80_0000, 32'h0000_0000, 4'd7, 1'b1, 32'h7F80_0000, 4'b0100);
    wait_idle("div");
    sb_drain("div");
    check("div_sticky", sticky_flags, 4'b0100);
    minv = '0;
    sticky_clr = 1'b1;
    step(1);
    sticky_clr = 1'b0;
    check("div_sticky_clr", sticky_flags, 0);

    // Clear held across a push: the new flags survive
    mdelay[1] = 2; mres[1] = 32'h7F7F_FFFF; movf = 4'b0010;
    sticky_clr = 1'b1;
    send(OP_MUL, 32'h7F00_0000, 32'h7F00_0000, 4'd9, 1'b1, 32'h7F7F_FFFF, 4'b0001);
    wait_idle("setwin");
    sticky_clr = 1'b0;
    check("setwin_sticky", sticky_flags, 4'b0001);
    step(1);
    check("setwin_sticky_hold", sticky_flags, 4'b0001);
    movf = '0;
    sb_drain("setwin");

    // Illegal opcode: no unit started, invalid result straight to the FIFO
    c = start_cnt;
    send(4'hC, 32'h1, 32'h2, 4'd2, 1'b1, 32'h0, 4'b0100);
    check("ill_busy", busy, 1);
    step(1);
    check("ill_out_valid", out_valid, 1);
    check("ill_out_tag", out_tag, 2);
    check("ill_out_result", out_result, 0);
    check("ill_out_flags", out_flags, 4'b0100);
    wait_idle("ill");
    sb_drain("ill");
    check("ill_no_start", start_cnt, c);

    // Fill the FIFO with the consumer stalled, then release in order
    out_ready = 1'b0;
    mdelay[1] = 2;
    for (int k = 0; k < 4; k++) begin
      mres[1] = 32'h3F00_0000 + k;
      send(OP_MUL, 32'(k), 32'(k), 4'(8 + k), 1'b1, 32'h3F00_0000 + k, 4'b0000);
      wait_idle("fill");
    end
    check("fill_count", fifo_count, 4);
    check("fill_in_ready", in_ready, 0);
    check("fill_head_tag", out_tag, 8);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check("fill_pop_count", fifo_count, 3);
    check("fill_pop_in_ready", in_ready, 1);
    check("fill_next_tag", out_tag, 9);
    out_ready = 1'b1;
    step(4);
    check("fill_drained", fifo_count, 0);
    sb_drain("fill");

    // Reset while waiting on a unit with a result queued
    out_ready = 1'b0;
    mdelay[0] = 2;
    send(OP_ADD, 32'h1, 32'h2, 4'd1, 1'b0, 32'h0, 4'b0000);
    wait_idle("rm_pre");
    check("rm_count_pre", fifo_count, 1);
    mdelay[0] = 6;
    send(OP_SUB, 32'h3, 32'h4, 4'd3, 1'b0, 32'h0, 4'b0000);
    step(2);
    check("rm_busy_wait", busy, 1);
    reset = 1'b1;
    #1;
    check("rm_unit_start", unit_start, 0);
    check("rm_out_valid", out_valid, 0);
    check("rm_fifo_count", fifo_count, 0);
    check("rm_busy", busy, 0);
    check("rm_in_ready", in_ready, 0);
    step(2);
    reset = 1'b0;
    step(10);
    check("rm_late_count", fifo_count, 0);
    check("rm_late_valid", out_valid, 0);
    check("rm_late_busy", busy, 0);
    check("rm_sticky", sticky_flags, 0);
    sb_drain("rm");

    // Unit that never answers
    out_ready = 1'b0;
    mdelay[1] = 0; mres[1] = 32'h1234_5678;
`ifdef FP_ALU_SEQ_TIMEOUT_EN
    send(OP_MUL, 32'h5, 32'h6, 4'd6, 1'b1, 32'h7FC0_0000, 4'b1100);
    wait_idle("tmo");
    check("tmo_count", fifo_count, 1);
    check("tmo_result", out_result, 32'h7FC0_0000);
    check("tmo_flags", out_flags, 4'b1100);
    check("tmo_tag", out_tag, 6);
    pulse_done(1);
    step(3);
    check("tmo_late_count", fifo_count, 1);
    check("tmo_late_busy", busy, 0);
`else
    send(OP_MUL, 32'h5, 32'h6, 4'd6, 1'b1, 32'h1234_5678, 4'b0000);
    step(20);
    check("hang_busy", busy, 1);
    check("hang_count", fifo_count, 0);
    pulse_done(1);
    wait_idle("hang");
    check("hang_count_done", fifo_count, 1);
`endif
    out_ready = 1'b1;
    step(2);
    sb_drain("tail");
    check("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_alu_sequencer.md
Name: fp_alu_sequencer

Overview:
- Parametrised successor to the single-cycle-mux FP ALU wrapper.
- Accepts tagged FP requests over valid/ready, dispatches each to one of NUM_UNITS execution units (add/sub, mul, div, special) through generic start/done ports, and captures result and exception flags.
- Queues completed results in a result FIFO with valid/ready output, and keeps sticky exception flags.
- Sits between the calculator command decoder and the FP execution units.

Parameters:
- DATA_W, 32, FP word width (32 or 64).
- EXP_W, 8, exponent width (8 for DATA_W=32, 11 for 64); sets canonical qNaN.
- TAG_W, 4, request tag width, returned unchanged with the result.
- NUM_UNITS, 4, execution unit count; minimum 4; units 0..3 = add/sub, mul, div, special.
- FIFO_DEPTH, 4, result FIFO entries; power of two, ≥2.
- TIMEOUT_CYC, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_op  in  4  opcode (package encoding 0..7)
- in_a, in_b  in  DATA_W  operands
- in_tag  in  TAG_W  request tag
- unit_start  out  NUM_UNITS  one-hot start pulse
- unit_op  out  4  latched opcode to units
- unit_a, unit_b  out  DATA_W  latched operands, stable from ISSUE to capture
- unit_done  in  NUM_UNITS  per-unit done
- unit_result  in  NUM_UNITS*DATA_W  packed results, unit i at [i*DATA_W +: DATA_W]
- unit_ovf, unit_unf, unit_inv  in  NUM_UNITS  per-unit exception flags, valid with done
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer pop
- out_result  out  DATA_W  head result
- out_tag  out  TAG_W  head tag
- out_flags  out  4  head flags {timeout, invalid, underflow, overflow}
- sticky_flags  out  4  OR of all flags pushed since reset or clear
- sticky_clr  in  1  clear sticky flags
- busy  out  1  state != IDLE
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries

Behaviour:
- Reset: asynchronous, active-high, on reset; clock clk. Reset values:
  - state IDLE; FIFO empty.
  - out_valid=0, in_ready=0 while reset is asserted.
  - unit_start=0, unit_op/unit_a/unit_b=0, sticky_flags=0, busy=0, fifo_count=0.
  - out_result/out_tag/out_flags=0.
- Reset mid-operation aborts the in-flight op and drops all queued results.
- FSM: IDLE, ISSUE, WAIT, PUSH.
- IDLE:
  - in_ready = !reset && fifo_count < FIFO_DEPTH.
  - On accept, latch op/a/b/tag and compute sel = op_to_unit(op).
  - Legal op -> ISSUE.
  - Illegal op (8..15) -> PUSH with result 0 and flags invalid=1.
- ISSUE: unit_start[sel]=1 for exactly one cycle -> WAIT.
- WAIT:
  - Sample only unit_done[sel]. When high, capture unit_result slice, ovf, unf, inv -> PUSH.
  - unit_done from any other unit, or at any time outside WAIT, is ignored.
  - Units must not assert done in the start cycle. The special unit (3) asserts done the cycle after start.
- PUSH: write {result, tag, flags} into the FIFO -> IDLE.
- Latency: accept at edge T; start high T..T+1; done seen at edge D; FIFO write at edge D+1; out_valid high after D+1 if FIFO was empty.
- Throughput: one op in flight. The next accept is possible the cycle after PUSH.
- FIFO:
  - First-word-fall-through; head visible while out_valid.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - No overflow possible: space is checked at accept, and only one op is in flight.
  - Pop on empty is ignored.
- Sticky flags: OR-in the pushed flags at each PUSH. If sticky_clr and PUSH occur in the same cycle, the result is the new flags only (set wins over clear).
- busy=1 in ISSUE, WAIT and PUSH.

Optional Feature:
- Macro FP_ALU_SEQ_TIMEOUT_EN.
- Defined:
  - Cycle counter runs in WAIT, cleared on entering WAIT.
  - On reaching TIMEOUT_CYC without done -> PUSH with result = canonical qNaN (sign 0, exponent all-ones, mantissa MSB 1) and flags timeout=1, invalid=1.
  - A late done from the timed-out unit is ignored.
- Undefined: WAIT holds indefinitely; no counter logic is built; timeout flag bit is constant 0.

Decomposition:
- Package fp_alu_pkg:
  - opcode constants (ADD 0, SUB 1, MUL 2, DIV 3, ABS 4, NEG 5, MIN 6, MAX 7).
  - flag bit indices (OVF 0, UNF 1, INV 2, TMO 3).
  - FSM state enum.
  - function op_to_unit (0,1->0; 2->1; 3->2; 4..7->3).
  - function qnan(DATA_W, EXP_W).
- Sub-module fp_result_fifo: parametrised by entry width and depth; push/pop/count/full/empty.

Test Plan:
- ADD a=0x3F800000, b=0x40000000, tag=5, adder model done after 3 cycles with 0x40400000 -> out_result=0x40400000, out_tag=5, out_flags=0; out_valid asserted one cycle after done capture.
- DIV a=0x3F800000, b=0x00000000, unit_inv=1, result 0x7F800000 -> out_flags=4'b0100; sticky_flags=4'b0100; sticky_clr afterwards -> 0.
- Illegal op 4'hC, tag 2 -> no unit_start pulse; out_result=0, out_flags=4'b0100 within 2 cycles of accept.
- out_ready=0 with FIFO_DEPTH=4: four MUL ops complete -> in_ready=0 and fifo_count=4; one pop -> in_ready=1 the same cycle; tags are popped in issue order.
- Reset asserted during WAIT -> unit_start=0, out_valid=0, fifo_count=0, busy=0 immediately; a subsequent done is ignored.
- With FP_ALU_SEQ_TIMEOUT_EN, TIMEOUT_CYC=8, unit never sets done -> push of 0x7FC00000 with flags 4'b1100; a late done is ignored. Without the macro -> busy stays 1.
